// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_pkg
// Description : Shared types, defaults and helper functions for the switch
//               rendezvous scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_pkg;

    localparam int CORE_SIZE_DEFAULT = 8;

    typedef logic [$clog2(CORE_SIZE_DEFAULT)-1:0] core_idx_t;

    // Index width for n endpoints; a single endpoint still needs one bit.
    function automatic int addr_size(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Number of set bits; the caller zero-extends narrower vectors.
    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {31'b0, v[i]};
        end
        return c;
    endfunction

endpackage : switch_pkg
`default_nettype wire

// File: rtl/rr_multi_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_multi_pick
// Description : Combinational round-robin picker. Starting at the pointer and
//               wrapping, grants the first LANES set request bits and reports
//               the index of the last one granted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_multi_pick #(
    parameter int N     = 8,
    parameter int LANES = 2,
    parameter int AW    = 3
) (
    input  logic [N-1:0]  req,
    input  logic [AW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [AW-1:0] last,
    output logic          any
);

    int          w_cnt;
    int          w_pos;
    logic [AW-1:0] w_idx;

    // Walk the requests from the start pointer, wrapping modulo N.
    always_comb begin
        grant = '0;
        last  = start;
        any   = 1'b0;
        w_cnt = 0;
        w_pos = 0;
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = int'(start) + i;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_idx = AW'(w_pos);
            if (req[w_idx] && (w_cnt < LANES)) begin
                grant[w_idx] = 1'b1;
                w_cnt        = w_cnt + 1;
                last         = w_idx;
                any          = 1'b1;
            end
        end
    end

endmodule : rr_multi_pick
`default_nettype wire

// File: rtl/switch_sched.sv
`default_nettype none
// ============================================================================
// Module      : switch_sched
// Description : Rendezvous scheduler for the inter-core switch. Pairs receiver
//               requests with sender readiness, admits up to LANES transfers
//               per cycle with round-robin fairness, and drives handshake
//               pulses, crossbar selects, stall flags and a transfer counter.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_sched
    import switch_pkg::*;
#(
    parameter int CORE_SIZE = CORE_SIZE_DEFAULT,
    parameter int LANES     = 2,
    parameter int TIMEOUT   = 1023,
    parameter int ADDR_SIZE = addr_size(CORE_SIZE)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CORE_SIZE-1:0]           send_ready,
    input  logic [CORE_SIZE*ADDR_SIZE-1:0] send_core_idx,
    input  logic [CORE_SIZE-1:0]           recv_request,
    input  logic [CORE_SIZE*ADDR_SIZE-1:0] recv_core_idx,
    output logic [CORE_SIZE-1:0]           send_ok,
    output logic [CORE_SIZE-1:0]           recv_ready,
    output logic [CORE_SIZE*ADDR_SIZE-1:0] recv_sel,
    output logic [CORE_SIZE-1:0]           stall,
    output logic                           self_err,
    output logic [31:0]                    xfer_count
);

    localparam int c_wait_w = $clog2(TIMEOUT + 1);
    localparam logic [c_wait_w-1:0] c_timeout = c_wait_w'(TIMEOUT);

    logic [ADDR_SIZE-1:0] w_src   [CORE_SIZE];
    logic [ADDR_SIZE-1:0] w_dst   [CORE_SIZE];
    logic [CORE_SIZE-1:0] w_match;
    logic [CORE_SIZE-1:0] w_self_req;
    logic [CORE_SIZE-1:0] w_grant;
    logic [CORE_SIZE-1:0] w_send_ok_nxt;
    logic [ADDR_SIZE-1:0] w_last;
    logic                 w_any;

    logic [CORE_SIZE-1:0] r_send_ok;
    logic [CORE_SIZE-1:0] r_recv_ready;
    logic [ADDR_SIZE-1:0] r_sel   [CORE_SIZE];
    logic [c_wait_w-1:0]  r_wait  [CORE_SIZE];
    logic [ADDR_SIZE-1:0] r_rr_ptr;
    logic                 r_self_err;
    logic [31:0]          r_xfer_count;

    generate
        for (genvar g = 0; g < CORE_SIZE; g++) begin : g_port
            assign w_src[g] = recv_core_idx[g*ADDR_SIZE +: ADDR_SIZE];
            assign w_dst[g] = send_core_idx[g*ADDR_SIZE +: ADDR_SIZE];
            assign recv_sel[g*ADDR_SIZE +: ADDR_SIZE] = r_sel[g];
            assign stall[g] = (r_wait[g] == c_timeout);
        end
    endgenerate

    // Rendezvous match; recv_ready doubles as the busy mask. Out-of-range
    // sources never compare equal to a real sender, so they never match.
    always_comb begin
        w_match    = '0;
        w_self_req = '0;
        for (int r = 0; r < CORE_SIZE; r++) begin
            for (int s = 0; s < CORE_SIZE; s++) begin
                if (recv_request[r] && !r_recv_ready[r] && (s != r) &&
                    (w_src[r] == ADDR_SIZE'(s)) && send_ready[s] &&
                    (w_dst[s] == ADDR_SIZE'(r))) begin
                    w_match[r] = 1'b1;
                end
            end
            w_self_req[r] = recv_request[r] && (w_src[r] == ADDR_SIZE'(r));
        end
    end

    rr_multi_pick #(
        .N     (CORE_SIZE),
        .LANES (LANES),
        .AW    (ADDR_SIZE)
    ) u_pick (
        .req   (w_match),
        .start (r_rr_ptr),
        .grant (w_grant),
        .last  (w_last),
        .any   (w_any)
    );

    // Each granted receiver releases the sender it asked for.
    always_comb begin
        w_send_ok_nxt = '0;
        for (int r = 0; r < CORE_SIZE; r++) begin
            for (int s = 0; s < CORE_SIZE; s++) begin
                if (w_grant[r] && (w_src[r] == ADDR_SIZE'(s))) begin
                    w_send_ok_nxt[s] = 1'b1;
                end
            end
        end
    end

    // Handshake pulses, round-robin pointer, sticky error and transfer count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_send_ok    <= '0;
            r_recv_ready <= '0;
            r_rr_ptr     <= '0;
            r_self_err   <= 1'b0;
            r_xfer_count <= '0;
        end else begin
            r_send_ok    <= w_send_ok_nxt;
            r_recv_ready <= w_grant;
            if (w_any) begin
                r_rr_ptr <= (int'(w_last) == CORE_SIZE - 1) ? '0 : w_last + 1'b1;
            end
            if (|w_self_req) begin
                r_self_err <= 1'b1;
            end
            r_xfer_count <= r_xfer_count + popcount(32'(w_grant));
        end
    end

    // Crossbar selects hold until the receiver's next grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < CORE_SIZE; r++) begin
                r_sel[r] <= '0;
            end
        end else begin
            for (int r = 0; r < CORE_SIZE; r++) begin
                if (w_grant[r]) begin
                    r_sel[r] <= w_src[r];
                end
            end
        end
    end

    // Per-receiver wait counters, saturating at TIMEOUT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < CORE_SIZE; r++) begin
                r_wait[r] <= '0;
            end
        end else begin
            for (int r = 0; r < CORE_SIZE; r++) begin
                if (!recv_request[r] || w_grant[r]) begin
                    r_wait[r] <= '0;
                end else if (r_wait[r] != c_timeout) begin
                    r_wait[r] <= r_wait[r] + 1'b1;
                end
            end
        end
    end

    assign send_ok    = r_send_ok;
    assign recv_ready = r_recv_ready;
    assign self_err   = r_self_err;
    assign xfer_count = r_xfer_count;

endmodule : switch_sched
`default_nettype wire

// File: tb/tb_switch_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_sched
// Description : Self-checking bench for switch_sched with a transaction-level
//               reference model (directed scenarios plus random traffic).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_sched;

    localparam int N  = 8;
    localparam int LN = 2;
    localparam int TO = 15;
    localparam int AW = 3;

    logic            clock;
    logic            reset;
    logic [N-1:0]    send_ready;
    logic [N*AW-1:0] send_core_idx;
    logic [N-1:0]    recv_request;
    logic [N*AW-1:0] recv_core_idx;
    logic [N-1:0]    send_ok;
    logic [N-1:0]    recv_ready;
    logic [N*AW-1:0] recv_sel;
    logic [N-1:0]    stall;
    logic            self_err;
    logic [31:0]     xfer_count;

    switch_sched #(
        .CORE_SIZE (N),
        .LANES     (LN),
        .TIMEOUT   (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .send_ready    (send_ready),
        .send_core_idx (send_core_idx),
        .recv_request  (recv_request),
        .recv_core_idx (recv_core_idx),
        .send_ok       (send_ok),
        .recv_ready    (recv_ready),
        .recv_sel      (recv_sel),
        .stall         (stall),
        .self_err      (self_err),
        .xfer_count    (xfer_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stimulus as plain per-core arrays.
    bit sr [N];
    int sd [N];
    bit rq [N];
    int rs [N];

    // Reference model state.
    bit          m_so   [N];
    bit          m_ro   [N];
    int          m_sel  [N];
    int          m_wait [N];
    int          m_ptr;
    bit          m_self;
    int unsigned m_cnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            sr[i] = 0; sd[i] = 0; rq[i] = 0; rs[i] = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_so[i] = 0; m_ro[i] = 0; m_sel[i] = 0; m_wait[i] = 0;
        end
        m_ptr  = 0;
        m_self = 0;
        m_cnt  = 0;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            send_ready[i]              = sr[i];
            send_core_idx[i*AW +: AW]  = AW'(sd[i]);
            recv_request[i]            = rq[i];
            recv_core_idx[i*AW +: AW]  = AW'(rs[i]);
        end
    endtask

    // One clock of the rendezvous rules applied to the current stimulus.
    task automatic model_step();
        bit match [N];
        int q[$];
        for (int r = 0; r < N; r++) begin
            match[r] = rq[r] && (rs[r] != r) && sr[rs[r]] && (sd[rs[r]] == r) && !m_ro[r];
            if (rq[r] && rs[r] == r) m_self = 1;
        end
        for (int k = 0; k < N; k++) begin
            int r;
            r = (m_ptr + k) % N;
            if (match[r] && q.size() < LN) q.push_back(r);
        end
        for (int i = 0; i < N; i++) begin
            m_so[i] = 0; m_ro[i] = 0;
        end
        foreach (q[i]) begin
            m_ro[q[i]]     = 1;
            m_so[rs[q[i]]] = 1;
            m_sel[q[i]]    = rs[q[i]];
        end
        m_cnt += q.size();
        if (q.size() > 0) m_ptr = (q[q.size()-1] + 1) % N;
        for (int r = 0; r < N; r++) begin
            if (!rq[r] || m_ro[r]) m_wait[r] = 0;
            else if (m_wait[r] < TO) m_wait[r]++;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0]    e_so, e_ro, e_st;
        logic [N*AW-1:0] e_sel;
        for (int i = 0; i < N; i++) begin
            e_so[i] = m_so[i];
            e_ro[i] = m_ro[i];
            e_st[i] = (m_wait[i] == TO);
            e_sel[i*AW +: AW] = AW'(m_sel[i]);
        end
        check("send_ok",    64'(send_ok),    64'(e_so));
        check("recv_ready", 64'(recv_ready), 64'(e_ro));
        check("recv_sel",   64'(recv_sel),   64'(e_sel));
        check("stall",      64'(stall),      64'(e_st));
        check("self_err",   64'(self_err),   64'(m_self));
        check("xfer_count", 64'(xfer_count), 64'(m_cnt));
    endtask

    // Drive current stimulus, advance one edge, check everything.
    task automatic cycle();
        apply();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_send_ok"},    64'(send_ok),    64'd0);
        check({tag, "_recv_ready"}, 64'(recv_ready), 64'd0);
        check({tag, "_recv_sel"},   64'(recv_sel),   64'd0);
        check({tag, "_stall"},      64'(stall),      64'd0);
        check({tag, "_self_err"},   64'(self_err),   64'd0);
        check({tag, "_xfer_count"}, 64'(xfer_count), 64'd0);
    endtask

    // Reset asserted between edges: outputs must clear without a clock.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_reset_state(tag);
        clear_inputs();
        apply();
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        apply();
        model_reset();
        #2;
        do_reset("por");

        // Single transfer: sender 4 -> 0.
        sr[4] = 1; sd[4] = 0; rq[0] = 1; rs[0] = 4;
        cycle();
        check("t1_recv_ready0", 64'(recv_ready[0]), 64'd1);
        check("t1_send_ok4",    64'(send_ok[4]),    64'd1);
        check("t1_recv_sel0",   64'(recv_sel[2:0]), 64'd4);
        check("t1_count",       64'(xfer_count),    64'd1);
        clear_inputs();
        cycle();
        check("t1_pulse_end",   64'(recv_ready),    64'd0);
        check("t1_sel_hold",    64'(recv_sel[2:0]), 64'd4);

        // Lane limit from pointer 0.
        do_reset("rst2");
        for (int r = 0; r < 3; r++) begin
            sr[4+r] = 1; sd[4+r] = r; rq[r] = 1; rs[r] = 4 + r;
        end
        cycle();
        check("t2_first",  64'(recv_ready), 64'h03);
        cycle();
        check("t2_second", 64'(recv_ready), 64'h04);
        check("t2_count",  64'(xfer_count), 64'd3);
        clear_inputs();
        cycle();

        // Mismatch leads to stall, then resolution.
        rq[2] = 1; rs[2] = 5; sr[5] = 1; sd[5] = 3;
        for (int i = 0; i < TO - 1; i++) cycle();
        check("t4_no_stall_yet", 64'(stall[2]), 64'd0);
        cycle();
        check("t4_stall",        64'(stall[2]), 64'd1);
        rq[3] = 1; rs[3] = 5;
        cycle();
        check("t4_r3_grant",     64'(recv_ready[3]), 64'd1);
        rq[3] = 0; sd[5] = 2;
        cycle();
        check("t4_r2_grant",     64'(recv_ready[2]), 64'd1);
        check("t4_stall_clear",  64'(stall[2]),      64'd0);
        clear_inputs();
        cycle();

        // Self request alongside a legal transfer.
        rq[6] = 1; rs[6] = 6; sr[6] = 1; sd[6] = 6;
        rq[0] = 1; rs[0] = 4; sr[4] = 1; sd[4] = 0;
        cycle();
        check("t5_self_err",  64'(self_err),      64'd1);
        check("t5_no_grant6", 64'(recv_ready[6]), 64'd0);
        check("t5_other_ok",  64'(recv_ready[0]), 64'd1);
        clear_inputs();
        cycle();
        check("t5_sticky",    64'(self_err),      64'd1);

        // Every receiver permanently matched: rotation through the ring.
        do_reset("rst3");
        for (int i = 0; i < N; i++) begin
            sr[i] = 1; sd[i] = i ^ 4; rq[i] = 1; rs[i] = i ^ 4;
        end
        for (int i = 0; i < 16; i++) cycle();
        clear_inputs();
        cycle();

        // Random traffic with persistent request lines.
        for (int i = 0; i < N; i++) begin
            sr[i] = 1'($urandom_range(0, 1)); sd[i] = $urandom_range(0, N-1);
            rq[i] = 1'($urandom_range(0, 1)); rs[i] = $urandom_range(0, N-1);
        end
        for (int c = 0; c < 600; c++) begin
            for (int s = 0; s < N; s++) begin
                if ($urandom_range(0, 3) == 0) begin
                    sr[s] = 1'($urandom_range(0, 1));
                    sd[s] = $urandom_range(0, N-1);
                end
            end
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(0, 5) == 0) begin
                    rq[r] = 1'($urandom_range(0, 1));
                    rs[r] = $urandom_range(0, N-1);
                    if ($urandom_range(0, 1) == 1) begin
                        for (int s = 0; s < N; s++) if (sd[s] == r) rs[r] = s;
                    end
                end
            end
            cycle();
        end
        clear_inputs();
        cycle();

        // Reset while recv_ready[1] is high, then re-request.
        sr[3] = 1; sd[3] = 1; rq[1] = 1; rs[1] = 3;
        cycle();
        check("t6_pre_reset", 64'(recv_ready[1]), 64'd1);
        do_reset("t6_mid");
        sr[3] = 1; sd[3] = 1; rq[1] = 1; rs[1] = 3;
        cycle();
        check("t6_regrant", 64'(recv_ready[1]), 64'd1);
        check("t6_count",   64'(xfer_count),    64'd1);
        clear_inputs();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_switch_sched
`default_nettype wire

// File: doc/switch_sched.md
Name: switch_sched

Overview:
- Rendezvous scheduler for the inter-core switch.
- Pairs each receiver's recv_request(source idx) with the matching sender's send_ready(destination idx).
- Admits at most LANES transfers per cycle using round-robin fairness over receivers, and drives the handshake pulses and per-receiver crossbar selects.
- Sits between the 8 cores (4 matrix, 4 vector) and the switch data crossbar; it carries no payload itself.

Parameters:
- CORE_SIZE, 8, number of switch endpoints.
- LANES, 2, maximum concurrent transfers granted per cycle (1..CORE_SIZE).
- TIMEOUT, 1023, wait cycles after which a pending receiver is flagged stalled.
- ADDR_SIZE, $clog2(CORE_SIZE), core index width (derived).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- send_ready  in  CORE_SIZE  sender s has data pending.
- send_core_idx  in  CORE_SIZE*ADDR_SIZE  destination of sender s.
- recv_request  in  CORE_SIZE  receiver r wants data.
- recv_core_idx  in  CORE_SIZE*ADDR_SIZE  source requested by receiver r.
- send_ok  out  CORE_SIZE  1-cycle pulse: sender s's data is taken.
- recv_ready  out  CORE_SIZE  1-cycle pulse: receiver r's data is valid on the crossbar.
- recv_sel  out  CORE_SIZE*ADDR_SIZE  crossbar source select for receiver r.
- stall  out  CORE_SIZE  receiver r has waited at least TIMEOUT cycles.
- self_err  out  1  sticky: some receiver requested itself.
- xfer_count  out  32  total granted transfers, wrapping.

Behaviour:
- Reset (async, active-high): send_ok=0, recv_ready=0, recv_sel=0, stall=0, self_err=0, xfer_count=0, rr_ptr=0, all wait counters 0, busy mask 0.
- Match: match[r] = recv_request[r] & send_ready[s] & (send_core_idx[s]==r) & ~busy[r] & (s!=r), where s=recv_core_idx[r].
  - A sender has one destination, so at most one receiver matches any sender; no sender conflict is possible.
- Arbitration: scan receivers from rr_ptr upward, wrapping modulo CORE_SIZE. Grant the first min(LANES, popcount(match)) matched receivers.
- Latency: inputs are sampled at edge k; outputs are registered and valid in the cycle after edge k:
  - send_ok[s]=1, recv_ready[r]=1, recv_sel[r]=s, xfer_count += number of grants.
- Pulses are exactly one cycle wide. recv_sel[r] holds its value until the next grant to r; it is never cleared by deassert.
- Busy mask: busy[r] is set for exactly the cycle in which recv_ready[r] is high.
  - This prevents a double grant while requesters are dropping their request lines.
  - Senders and receivers must deassert within that cycle. If they stay high, a new transfer is matched the following cycle, which is legal back-to-back use.
- rr_ptr: on any grant, set to (last granted r + 1) mod CORE_SIZE; unchanged when nothing is granted.
- Wait counter per receiver:
  - Increments while recv_request[r] & ~grant[r], saturating at TIMEOUT.
  - Cleared on grant or on request deassert.
  - stall[r] = (counter==TIMEOUT); it drops the cycle after the clear.
- Self-request (recv_core_idx[r]==r with recv_request[r]): never matched; sets self_err, which stays set until reset.
- Out-of-range indices (>= CORE_SIZE, non-power-of-2 CORE_SIZE only): treated as no match.
- Reset asserted mid-transfer: pulses are aborted immediately and no partial count is kept. Cores re-request after reset.
- Simultaneous grant and request drop in the same cycle: the grant stands and the core must accept the pulse.

Decomposition:
- Package switch_pkg:
  - CORE_SIZE_DEFAULT and ADDR_SIZE function.
  - core_idx_t typedef.
  - Popcount function used for the xfer_count increment.
- Sub-module rr_multi_pick: combinational round-robin picker. Inputs: request vector and start pointer. Outputs: grant vector of up to LANES bits, and last-granted index.
- Counters, busy mask and output registers stay in switch_sched.

Test Plan:
1. Single transfer: sender 4 -> dest 0, receiver 0 requests src 4 at cycle 1 -> send_ok[4]=recv_ready[0]=1 at cycle 2 only, recv_sel[0]=4, xfer_count=1.
2. Lane limit: receivers 0,1,2 all matched with senders 4,5,6 at once, LANES=2, rr_ptr=0 -> cycle+1 grants r0,r1 and rr_ptr=2; cycle+2 is busy-masked for r0,r1, r2 is granted; xfer_count=3.
3. Fairness: all 8 receivers permanently matched (loops 0<-4, 4<-0, etc.) with LANES=1 -> grants rotate 0,1,...,7,0; no receiver waits more than 8 cycles.
4. Mismatch and stall: receiver 2 requests src 5 while sender 5 targets 3, TIMEOUT=15 -> no grant, stall[2] rises after 15 cycles; on receiver 3 taking sender 5 and sender 5 then targeting 2, r2 is granted and stall[2] clears next cycle.
5. Self request: receiver 6 requests src 6 with sender 6 ready to 6 -> no grant, self_err=1 and held; other transfers are unaffected.
6. Reset mid-operation: assert reset on the cycle recv_ready[1]=1 -> all outputs 0 asynchronously, xfer_count=0; after release, a re-request is granted with 1-cycle latency.
